ex_div_seq: RTL

Iterative RV32M divide/remainder sequencer attached beside the execute stage. It accepts DIV/DIVU/REM/REMU operands when the decoded instruction reaches EX. It then runs a radix-2 restoring division over XLEN cycles and holds the pipeline with a stall signal until the result is ready. The EX result mux selects its registered result on the done cycle.

---
 rtl/ex_div_seq.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ex_div_seq.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit beside EX.
// Ports: clk, rst, start, funct3, opa, opb, flush -> stall, busy, done, result.
module ex_div_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dvsr_q;
  logic [XLEN-1:0]  result_q;
  logic             negq_q;
  logic             negr_q;
  logic             is_rem_q;

  logic            op_rem;
  logic            op_sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            ovf;
  logic            special;
  logic            accept;
  logic [XLEN-1:0] spec_quo;
  logic [XLEN-1:0] spec_rem;

  logic [XLEN:0]   shl;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] fin_q;
  logic [XLEN-1:0] fin_r;
  logic [XLEN-1:0] fin;
  logic            last;

  // Unknown funct3 codes fall through as DIVU.
  assign op_rem = (funct3 == 3'b110) ||
                  (funct3 == 3'b111);
  assign op_sgn = (funct3 == 3'b100) ||
                  (funct3 == 3'b110);

  assign a_neg = op_sgn & opa[XLEN-1];
  assign b_neg = op_sgn & opb[XLEN-1];
  assign a_mag = a_neg ? (~opa + 1'b1) : opa;
  assign b_mag = b_neg ? (~opb + 1'b1) : opb;

  assign div_zero = (opb == '0);
  assign ovf      = op_sgn &&
                    (opa == MIN_NEG) &&
                    (opb == '1);
  assign special  = div_zero | ovf;

  // Reset wins over start, so a start seen in
  // reset neither stalls nor launches.
  assign accept = (state_q == S_IDLE) &
                  start & ~flush & ~rst;

  always_comb begin
    spec_quo = '0;
    spec_rem = '0;
    unique case (1'b1)
      div_zero: begin
        spec_quo = '1;
        spec_rem = opa;
      end
      ovf: begin
        spec_quo = MIN_NEG;
        spec_rem = '0;
      end
      default: begin
        spec_quo = '0;
        spec_rem = '0;
      end
    endcase
  end

  // One restoring step; the extra top bit keeps
  // the shifted partial remainder exact.
  assign shl    = {rem_q, quo_q[XLEN-1]};
  assign diff   = shl - {1'b0, dvsr_q};
  assign ge     = (shl >= {1'b0, dvsr_q});
  assign rem_nx = ge ? diff[XLEN-1:0]
                     : shl[XLEN-1:0];
  assign quo_nx = {quo_q[XLEN-2:0], ge};

  assign fin_q = negq_q ? (~quo_nx + 1'b1) : quo_nx;
  assign fin_r = negr_q ? (~rem_nx + 1'b1) : rem_nx;
  assign fin   = is_rem_q ? fin_r : fin_q;
  assign last  = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = special ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (flush) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    stall = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stall = accept;
      end
      S_RUN: begin
        stall = 1'b1;
        busy  = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  // result only moves on the edge into DONE, so a
  // flush on the last RUN cycle leaves it intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      is_rem_q <= 1'b0;
    end else if (accept) begin
      is_rem_q <= op_rem;
      negq_q   <= ~op_rem & (a_neg ^ b_neg);
      negr_q   <= op_rem & a_neg;
      dvsr_q   <= b_mag;
      cnt_q    <= CNT_W'(XLEN-1);
      if (special) begin
        quo_q    <= spec_quo;
        rem_q    <= spec_rem;
        result_q <= op_rem ? spec_rem : spec_quo;
      end else begin
        quo_q <= a_mag;
        rem_q <= '0;
      end
    end else if (state_q == S_RUN && !flush) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      if (last) begin
        result_q <= fin;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign result = result_q;

endmodule
